// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite manager between NUM_REQ requesters, one manager transaction per grant.
// Round-robin by default; define AXI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module axi4_lite_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data,
  input  logic [NUM_REQ*WIDTH/8-1:0]    req_wr_strobe,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_stall,
  output logic [WIDTH-1:0]              req_rd_data,
  output logic                          req_access_fault,
  output logic                          mgr_rd_en,
  output logic                          mgr_wr_en,
  output logic [ADDR_WIDTH-1:0]         mgr_addr,
  output logic [WIDTH-1:0]              mgr_wr_data,
  output logic [WIDTH/8-1:0]            mgr_wr_strobe,
  input  logic [WIDTH-1:0]              mgr_rd_data,
  input  logic                          mgr_access_fault,
  input  logic                          mgr_busy
);
  localparam int STRB_W = WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state;
  logic [2:0]            grant;
  logic                  op_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  fault_q;

  logic [NUM_REQ-1:0]    req_any;
  logic                  win_found;
  logic [2:0]            win_idx;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic [STRB_W-1:0]     sel_strb;
  logic                  en_active;

  // A simultaneous read and write request is treated as a write
  assign req_any = req_rd_en | req_wr_en;

`ifdef AXI_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_any[k]) begin
        win_found = 1'b1;
        win_idx   = 3'(k);
      end
    end
  end
`else
  logic [2:0] rr_ptr;
  logic [7:0] req_pad;
  logic [3:0] cand;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req_any;
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_found && req_pad[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (state == S_DONE)
      rr_ptr <= (grant == 3'(NUM_REQ - 1)) ? 3'd0 : grant + 3'd1;
  end
`endif

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_wr    = req_wr_en[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wr_data[i*WIDTH +: WIDTH];
        sel_strb  = req_wr_strobe[i*STRB_W +: STRB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rd_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (win_found) begin
          grant   <= win_idx;
          op_wr   <= sel_wr;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          strb_q  <= sel_strb;
          state   <= S_ISSUE;
        end
        S_ISSUE: if (mgr_busy) state <= S_WAIT;
        S_WAIT: if (!mgr_busy) begin
          if (!op_wr) rd_data_q <= mgr_rd_data;
          fault_q <= mgr_access_fault;
          state   <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Enable drops in the same cycle busy falls so the manager never sees a second request
  assign en_active     = (state == S_ISSUE) || (state == S_WAIT && mgr_busy);
  assign mgr_rd_en     = en_active & ~op_wr;
  assign mgr_wr_en     = en_active & op_wr;
  assign mgr_addr      = addr_q;
  assign mgr_wr_data   = wdata_q;
  assign mgr_wr_strobe = strb_q;

  always_comb begin
    req_done = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_done[i] = (state == S_DONE) && (grant == 3'(i));
  end

  assign req_stall        = req_any & ~req_done;
  assign req_rd_data      = rd_data_q;
  assign req_access_fault = fault_q;
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Scoreboard bench for axi4_lite_arbiter: behavioural manager, per-port expectation queues, grant-order model.
module tb_axi4_lite_arbiter;
  localparam int NUM_REQ = 2;
  localparam int AW = 32;
  localparam int W  = 32;
  localparam int SW = W / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_REQ-1:0]    req_rd_en, req_wr_en, req_done, req_stall;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*W-1:0]  req_wr_data;
  logic [NUM_REQ*SW-1:0] req_wr_strobe;
  logic [W-1:0]          req_rd_data;
  logic                  req_access_fault;
  logic                  mgr_rd_en, mgr_wr_en;
  logic [AW-1:0]         mgr_addr;
  logic [W-1:0]          mgr_wr_data;
  logic [SW-1:0]         mgr_wr_strobe;
  logic [W-1:0]          mgr_rd_data;
  logic                  mgr_access_fault, mgr_busy;

  logic          p_rd[NUM_REQ], p_wr[NUM_REQ];
  logic [AW-1:0] p_addr[NUM_REQ];
  logic [W-1:0]  p_data[NUM_REQ];
  logic [SW-1:0] p_strb[NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_rd_en[g]               = p_rd[g];
    assign req_wr_en[g]               = p_wr[g];
    assign req_addr[g*AW +: AW]       = p_addr[g];
    assign req_wr_data[g*W +: W]      = p_data[g];
    assign req_wr_strobe[g*SW +: SW]  = p_strb[g];
  end

  axi4_lite_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_wr_strobe(req_wr_strobe),
    .req_done(req_done), .req_stall(req_stall), .req_rd_data(req_rd_data),
    .req_access_fault(req_access_fault),
    .mgr_rd_en(mgr_rd_en), .mgr_wr_en(mgr_wr_en), .mgr_addr(mgr_addr),
    .mgr_wr_data(mgr_wr_data), .mgr_wr_strobe(mgr_wr_strobe),
    .mgr_rd_data(mgr_rd_data), .mgr_access_fault(mgr_access_fault), .mgr_busy(mgr_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_REQ-1:0] req_at_edge = '0;
  always @(posedge clk) req_at_edge <= req_rd_en | req_wr_en;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic [W-1:0]  exp_rd;
    logic          exp_fault;
  } txn_t;

  txn_t         exp_q[NUM_REQ][$];
  int           grant_q[$];
  int           grant_log[$];
  logic [W-1:0] ref_mem[logic [AW-1:0]];
  logic [W-1:0] mgr_mem[logic [AW-1:0]];
  int           errors = 0;
  int           checks = 0;
  int           last_served = NUM_REQ - 1;
  logic         granted[NUM_REQ];
  int           raise_cyc[NUM_REQ];
  bit           chk_latency = 1'b0;
  int           fixed_busy = 0;
  int           fixed_delay = -1;
  logic [W-1:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Manager faults any address with bit 31 set and returns this pattern as read data
  function automatic logic [W-1:0] fault_data(input logic [AW-1:0] a);
    return 32'hBAD0_0000 ^ a;
  endfunction

  function automatic int expected_winner(input logic [NUM_REQ-1:0] reqs);
`ifdef AXI_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) if (reqs[k]) return k;
`else
    for (int k = 1; k <= NUM_REQ; k++)
      if (reqs[(last_served + k) % NUM_REQ]) return (last_served + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic port_txn(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [SW-1:0] s);
    txn_t t;
    logic [AW-1:0] key;
    logic [W-1:0] word;
    int n;
    key  = {a[AW-1:2], 2'b00};
    word = ref_mem.exists(key) ? ref_mem[key] : '0;
    t.wr = wr; t.addr = a; t.data = d; t.strb = s; t.exp_fault = a[AW-1]; t.exp_rd = '0;
    if (wr) begin
      if (!t.exp_fault) begin
        for (int b = 0; b < SW; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        ref_mem[key] = word;
      end
    end else begin
      t.exp_rd = t.exp_fault ? fault_data(a) : word;
    end
    exp_q[p].push_back(t);
    p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_data[p] = d; p_strb[p] = s;
    raise_cyc[p] = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (granted[p]) begin p_addr[p] = ~a; p_data[p] = ~d; p_strb[p] = ~s; end
    end while (!req_done[p] && n < 300);
    if (!req_done[p]) begin
      checks++; errors++;
      $display("FAIL done_timeout port %0d: no req_done after %0d cycles, expected a pulse", p, n);
    end
    p_rd[p] = 1'b0; p_wr[p] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mgr_rd_en"}, mgr_rd_en, 0);
    check({tag, "_mgr_wr_en"}, mgr_wr_en, 0);
    check({tag, "_req_done"}, req_done, 0);
    check({tag, "_req_stall"}, req_stall, 0);
    check({tag, "_rd_data"}, req_rd_data, 0);
    check({tag, "_fault"}, req_access_fault, 0);
    check({tag, "_mgr_addr"}, mgr_addr, 0);
    check({tag, "_mgr_wr_data"}, mgr_wr_data, 0);
    check({tag, "_mgr_strobe"}, mgr_wr_strobe, 0);
  endtask

  task automatic clear_model();
    for (int p = 0; p < NUM_REQ; p++) begin
      p_rd[p] = 1'b0; p_wr[p] = 1'b0; granted[p] = 1'b0;
      exp_q[p].delete();
    end
    grant_q.delete();
    last_rd = '0;
    last_served = NUM_REQ - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_port(input int p);
    int op;
    logic [AW-1:0] a;
    repeat (10) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = $urandom_range(0, 3);
      a  = 32'h200 + 32'h100 * p + 4 * $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) a[AW-1] = 1'b1;
      port_txn(p, op != 1, op == 1 || op == 2, a, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  // Behavioural manager plus grant/payload monitor
  initial begin : mgr_model
    txn_t cur;
    int g, delay, cnt;
    bit active;
    logic en, prev_en;
    logic [AW-1:0] key;
    logic [W-1:0] word;
    mgr_busy = 1'b0; mgr_rd_data = '0; mgr_access_fault = 1'b0;
    active = 1'b0; prev_en = 1'b0; delay = 0; cnt = 0; g = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; mgr_busy = 1'b0; prev_en = 1'b0;
        continue;
      end
      en = mgr_rd_en | mgr_wr_en;
      if (!active && en && !prev_en) begin
        g = expected_winner(req_at_edge);
        if (g < 0 || exp_q[g].size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_grant: enable with requests 0x%0h, expected no manager access", req_at_edge);
        end else begin
          cur = exp_q[g][0];
          grant_q.push_back(g);
          grant_log.push_back(g);
          granted[g] = 1'b1;
`ifndef AXI_ARB_FIXED_PRIO_EN
          last_served = g;
`endif
          check("issue_wr_en", mgr_wr_en, cur.wr);
          check("issue_rd_en", mgr_rd_en, !cur.wr);
          check("issue_addr", mgr_addr, cur.addr);
          if (cur.wr) begin
            check("issue_wr_data", mgr_wr_data, cur.data);
            check("issue_strobe", mgr_wr_strobe, cur.strb);
          end
          if (chk_latency) check("en_latency", cyc - raise_cyc[g], 1);
          active = 1'b1;
          delay  = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 2);
          cnt    = (fixed_busy > 0) ? fixed_busy : $urandom_range(1, 4);
        end
      end
      if (active && !mgr_busy) begin
        if (delay == 0) mgr_busy = 1'b1;
        else begin
          delay--;
          check("issue_hold", en, 1);
        end
      end else if (active && mgr_busy) begin
        check("busy_wr_en", mgr_wr_en, cur.wr);
        check("busy_rd_en", mgr_rd_en, !cur.wr);
        check("busy_addr", mgr_addr, cur.addr);
        if (cur.wr) begin
          check("busy_wr_data", mgr_wr_data, cur.data);
          check("busy_strobe", mgr_wr_strobe, cur.strb);
        end
        cnt--;
        if (cnt == 0) begin
          key = {cur.addr[AW-1:2], 2'b00};
          word = mgr_mem.exists(key) ? mgr_mem[key] : '0;
          mgr_access_fault = cur.addr[AW-1];
          if (cur.wr) begin
            mgr_rd_data = $urandom;
            if (!cur.addr[AW-1]) begin
              for (int b = 0; b < SW; b++) if (cur.strb[b]) word[8*b +: 8] = cur.data[8*b +: 8];
              mgr_mem[key] = word;
            end
          end else begin
            mgr_rd_data = cur.addr[AW-1] ? fault_data(cur.addr) : word;
          end
          mgr_busy = 1'b0;
          active = 1'b0;
          #1 check("en_drop", mgr_rd_en | mgr_wr_en, 0);
        end
      end
      prev_en = en;
    end
  end

  // Completion monitor: pops the expected grant and the port's expected response
  initial begin : done_mon
    txn_t t;
    int g;
    forever begin
      @(negedge clk);
      if (rst_n && req_done != '0) begin
        if (grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: req_done=0x%0h, expected none", req_done);
        end else begin
          g = grant_q.pop_front();
          check("done_onehot", req_done, 32'(1) << g);
          t = exp_q[g].pop_front();
          granted[g] = 1'b0;
          check("done_fault", req_access_fault, t.exp_fault);
          if (!t.wr) begin
            check("done_rd_data", req_rd_data, t.exp_rd);
            last_rd = t.exp_rd;
          end else begin
            check("done_rd_hold", req_rd_data, last_rd);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int exp_order[4];
    txn_t dummy;
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    clear_model();
    for (int p = 0; p < NUM_REQ; p++) begin
      p_addr[p] = '0; p_data[p] = '0; p_strb[p] = '0; raise_cyc[p] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Single read on port 1
    @(negedge clk);
    mgr_mem[32'h1004] = 32'hDEAD_BEEF;
    ref_mem[32'h1004] = 32'hDEAD_BEEF;
    chk_latency = 1'b1; fixed_busy = 3; fixed_delay = 0;
    fork
      port_txn(1, 1'b1, 1'b0, 32'h0000_1004, '0, '0);
      begin @(negedge clk); check("stall_p1", req_stall, 2'b10); end
    join
    check("t1_rd_data", req_rd_data, 32'hDEAD_BEEF);
    check("t1_fault", req_access_fault, 0);

    // Single write on port 0, then read back the partially strobed word
    @(negedge clk);
    port_txn(0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    port_txn(0, 1'b1, 1'b0, 32'h40, '0, '0);
    check("t2_readback", req_rd_data, 32'h0000_5678);

    // Faulting read, then a normal one
    @(negedge clk);
    fixed_busy = 2;
    port_txn(1, 1'b1, 1'b0, 32'h8000_0010, '0, '0);
    check("t4_fault", req_access_fault, 1);
    @(negedge clk);
    port_txn(0, 1'b1, 1'b0, 32'h40, '0, '0);
    check("t4_after_fault", req_access_fault, 0);

    // Read and write together means write
    @(negedge clk);
    port_txn(0, 1'b1, 1'b1, 32'h44, 32'hA5A5_5A5A, 4'hF);

    // Both ports requesting continuously from reset
    do_reset();
    chk_latency = 1'b0; fixed_busy = 0; fixed_delay = -1;
    grant_log.delete();
    fork
      begin
        port_txn(0, 1'b1, 1'b0, 32'h200, '0, '0);
        port_txn(0, 1'b1, 1'b0, 32'h204, '0, '0);
      end
      begin
        port_txn(1, 1'b1, 1'b0, 32'h300, '0, '0);
        port_txn(1, 1'b1, 1'b0, 32'h304, '0, '0);
      end
    join
    check("order_len", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("grant_order", grant_log[i], exp_order[i]);

    // Reset while waiting on the manager
    @(negedge clk);
    fixed_busy = 4; fixed_delay = 0;
    dummy = '{wr: 1'b0, addr: 32'h1004, data: '0, strb: '0, exp_rd: 32'hDEAD_BEEF, exp_fault: 1'b0};
    exp_q[1].push_back(dummy);
    p_rd[1] = 1'b1; p_addr[1] = 32'h1004;
    n = 0;
    while (!mgr_busy && n < 20) begin @(negedge clk); n++; end
    check("busy_seen", mgr_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    p_rd[1] = 1'b0;
    #1 check_zero("rst_wait");
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_no_done", req_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    grant_log.delete();
    fixed_busy = 0; fixed_delay = -1;
    fork
      port_txn(1, 1'b1, 1'b0, 32'h304, '0, '0);
      port_txn(0, 1'b1, 1'b0, 32'h204, '0, '0);
    join
    check("post_rst_len", grant_log.size(), 2);
    if (grant_log.size() > 0) check("post_rst_first", grant_log[0], 0);

    // Randomized traffic on both ports
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (3) @(negedge clk);
    check("grants_drained", grant_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
